// File: rtl/dmem_port_ctrl.sv
// Data-memory port controller: converts the MEM-stage level request into a req/ack
// handshake with a variable-latency word RAM, stalling the pipeline while outstanding.
module dmem_port_ctrl #(
    parameter int unsigned RAM_AW   = 30,
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_ren,
    input  logic              cpu_wen,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    output logic              addr_err,
    output logic              bus_err,
    output logic              ram_req,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic              ram_ack,
    input  logic [31:0]       ram_rdata
);

    // state | meaning
    // IDLE  | waiting for a MEM-stage request; aligned request is latched and launched
    // REQ   | ram_req held until ram_ack or timeout
    // DONE  | one stall-free cycle so the pipeline advances; request on cpu_* is not relaunched
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int unsigned    CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [RAM_AW-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                aerr_q, aerr_d;
    logic                berr_q, berr_d;

    logic cpu_req;
    logic aligned;
    logic accept;
    logic cnt_last;

    assign cpu_req  = cpu_ren | cpu_wen;
    assign aligned  = (cpu_addr[1:0] == 2'b00);
    assign accept   = (state_q == S_IDLE) && cpu_req && aligned;
    assign cnt_last = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_REQ;
            S_REQ:   if (ram_ack || cnt_last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cpu_stall = accept || (state_q == S_REQ);
        cnt_d     = cnt_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        aerr_d    = 1'b0;
        berr_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cpu_req && !aligned) aerr_d = 1'b1;
                if (accept) begin
                    req_d   = 1'b1;
                    we_d    = cpu_wen;
                    addr_d  = cpu_addr[RAM_AW+1:2];
                    wdata_d = cpu_wdata;
                    cnt_d   = '0;
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + 1'b1;
                // an ack arriving on the last allowed cycle still counts as success
                if (ram_ack) begin
                    req_d = 1'b0;
                    if (!we_q) rdata_d = ram_rdata;
                end else if (cnt_last) begin
                    req_d  = 1'b0;
                    berr_d = 1'b1;
                    if (!we_q) rdata_d = ERR_DATA;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            aerr_q  <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            aerr_q  <= aerr_d;
            berr_q  <= berr_d;
        end
    end

    assign ram_req   = req_q;
    assign ram_we    = we_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign cpu_rdata = rdata_q;
    assign addr_err  = aerr_q;
    assign bus_err   = berr_q;

endmodule

// File: tb/tb_dmem_port_ctrl.sv
// Self-checking bench for dmem_port_ctrl: transaction-level timeline model plus
// directed scenarios with literal expectations and a randomized operation mix.
module tb_dmem_port_ctrl;

    localparam int TMO = 16;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_ren, cpu_wen;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall, addr_err, bus_err;
    logic        ram_req, ram_we, ram_ack;
    logic [29:0] ram_addr;
    logic [31:0] ram_wdata, ram_rdata;

    dmem_port_ctrl #(.RAM_AW(30), .TIMEOUT(TMO), .ERR_DATA(ERRD)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_ren(cpu_ren), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .addr_err(addr_err), .bus_err(bus_err),
        .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_ack(ram_ack), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // expected per-cycle view of the outputs
    logic        chk_en = 1'b0;
    logic        exp_stall, exp_req, exp_we, exp_aerr, exp_berr;
    logic [29:0] exp_addr;
    logic [31:0] exp_wdata, exp_rdata;
    logic        pend_aerr;

    // observation counters, written only by the monitor
    int stall_n = 0, reqc_n = 0, rise_n = 0, aerr_n = 0, berr_n = 0;
    logic        prev_req = 1'b0;
    logic [29:0] last_addr = '0;
    logic        last_we = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cpu_stall", {31'd0, cpu_stall}, {31'd0, exp_stall});
            chk("ram_req",   {31'd0, ram_req},   {31'd0, exp_req});
            chk("cpu_rdata", cpu_rdata, exp_rdata);
            chk("addr_err",  {31'd0, addr_err},  {31'd0, exp_aerr});
            chk("bus_err",   {31'd0, bus_err},   {31'd0, exp_berr});
            if (exp_req) begin
                chk("ram_we",    {31'd0, ram_we}, {31'd0, exp_we});
                chk("ram_addr",  {2'd0, ram_addr}, {2'd0, exp_addr});
                chk("ram_wdata", ram_wdata, exp_wdata);
            end
        end
    end

    always @(negedge clk) begin
        if (cpu_stall) stall_n++;
        if (ram_req) begin
            reqc_n++;
            last_addr = ram_addr;
            last_we   = ram_we;
        end
        if (ram_req && !prev_req) rise_n++;
        if (addr_err) aerr_n++;
        if (bus_err) berr_n++;
        prev_req = ram_req;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One MEM-stage operation starting in an IDLE cycle. k = REQ cycle carrying the ack;
    // k > TMO means the RAM never answers.
    task automatic op(input logic ren, input logic wen, input logic [31:0] addr,
                      input logic [31:0] wdata, input int k, input logic [31:0] rd);
        logic tmo;
        int   nreq;
        tmo  = (k > TMO);
        nreq = tmo ? TMO : k;
        cpu_ren = ren; cpu_wen = wen; cpu_addr = addr; cpu_wdata = wdata;
        ram_ack = 1'($urandom_range(0, 1));
        ram_rdata = $urandom;
        exp_aerr = pend_aerr; pend_aerr = 1'b0;
        exp_berr = 1'b0; exp_req = 1'b0;
        if (!(ren || wen) || addr[1:0] != 2'b00) begin
            exp_stall = 1'b0;
            pend_aerr = ren || wen;
            next_cycle();
            return;
        end
        exp_stall = 1'b1;
        next_cycle();
        for (int j = 1; j <= nreq; j++) begin
            ram_ack   = (j == k);
            ram_rdata = (j == k) ? rd : $urandom;
            exp_req   = 1'b1;
            exp_we    = wen;
            exp_addr  = addr[31:2];
            exp_wdata = wdata;
            exp_stall = 1'b1;
            exp_aerr  = 1'b0;
            next_cycle();
        end
        ram_ack   = 1'($urandom_range(0, 1));
        ram_rdata = $urandom;
        exp_req   = 1'b0;
        exp_stall = 1'b0;
        if (!wen) exp_rdata = tmo ? ERRD : rd;
        exp_berr  = tmo;
        next_cycle();
    endtask

    int s0, q0, r0, a0, b0;
    task automatic snap();
        s0 = stall_n; q0 = reqc_n; r0 = rise_n; a0 = aerr_n; b0 = berr_n;
    endtask

    initial begin
        rst_n = 1'b0;
        cpu_ren = 1'b0; cpu_wen = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ram_ack = 1'b0; ram_rdata = '0;
        exp_stall = 1'b0; exp_req = 1'b0; exp_we = 1'b0; exp_aerr = 1'b0; exp_berr = 1'b0;
        exp_addr = '0; exp_wdata = '0; exp_rdata = '0; pend_aerr = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        chk("reset_ram_we",    {31'd0, ram_we}, 32'd0);
        chk("reset_ram_addr",  {2'd0, ram_addr}, 32'd0);
        chk("reset_ram_wdata", ram_wdata, 32'd0);
        chk("reset_cpu_rdata", cpu_rdata, 32'd0);

        // read, ack after one REQ cycle
        snap();
        op(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1, 32'h1234_5678);
        chk("t1_stall_cycles", stall_n - s0, 32'd2);
        chk("t1_ram_addr", {2'd0, last_addr}, 32'h4);
        chk("t1_rdata", cpu_rdata, 32'h1234_5678);

        // write, ack after five REQ cycles
        snap();
        op(1'b0, 1'b1, 32'h0000_0020, 32'hA5A5_A5A5, 5, 32'h0);
        chk("t2_stall_cycles", stall_n - s0, 32'd6);
        chk("t2_req_cycles", reqc_n - q0, 32'd5);
        chk("t2_ram_addr", {2'd0, last_addr}, 32'h8);
        chk("t2_ram_we", {31'd0, last_we}, 32'd1);
        chk("t2_rdata_kept", cpu_rdata, 32'h1234_5678);

        // misaligned read
        snap();
        op(1'b1, 1'b0, 32'h0000_0013, 32'h0, 1, 32'h0);
        op(1'b0, 1'b0, 32'h0, 32'h0, 1, 32'h0);
        chk("t3_no_req", rise_n - r0, 32'd0);
        chk("t3_no_stall", stall_n - s0, 32'd0);
        chk("t3_addr_err_pulses", aerr_n - a0, 32'd1);

        // timeout
        snap();
        op(1'b1, 1'b0, 32'h0000_0030, 32'h0, TMO + 1, 32'h0);
        chk("t4_req_cycles", reqc_n - q0, 32'd16);
        chk("t4_stall_cycles", stall_n - s0, 32'd17);
        chk("t4_bus_err_pulses", berr_n - b0, 32'd1);
        chk("t4_rdata", cpu_rdata, 32'hDEAD_BEEF);

        // back-to-back write then read, plus write-wins when both requested
        snap();
        op(1'b0, 1'b1, 32'h0000_0040, 32'h1111_2222, 1, 32'h0);
        op(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1, 32'h0BAD_F00D);
        chk("t5_req_bursts", rise_n - r0, 32'd2);
        chk("t5_stall_cycles", stall_n - s0, 32'd4);
        chk("t5_rdata", cpu_rdata, 32'h0BAD_F00D);
        op(1'b1, 1'b1, 32'h0000_0044, 32'h3333_4444, 2, 32'h5555_6666);
        chk("both_write_wins", {31'd0, last_we}, 32'd1);
        chk("both_rdata_kept", cpu_rdata, 32'h0BAD_F00D);

        // ack on the final allowed REQ cycle is a success, not a timeout
        snap();
        op(1'b1, 1'b0, 32'h0000_0050, 32'h0, TMO, 32'h7777_8888);
        chk("tlast_no_bus_err", berr_n - b0, 32'd0);
        chk("tlast_rdata", cpu_rdata, 32'h7777_8888);

        // reset during REQ cycle 3, then a late ack
        cpu_ren = 1'b1; cpu_wen = 1'b0; cpu_addr = 32'h0000_0060; ram_ack = 1'b0;
        exp_aerr = pend_aerr; pend_aerr = 1'b0; exp_berr = 1'b0;
        exp_stall = 1'b1; exp_req = 1'b0;
        next_cycle();
        for (int j = 0; j < 2; j++) begin
            exp_req = 1'b1; exp_we = 1'b0; exp_addr = 30'h18; exp_wdata = cpu_wdata;
            exp_stall = 1'b1; exp_aerr = 1'b0;
            next_cycle();
        end
        #2;
        rst_n = 1'b0; cpu_ren = 1'b0;
        exp_req = 1'b0; exp_stall = 1'b0; exp_rdata = '0;
        #1;
        chk("rst_req_async", {31'd0, ram_req}, 32'd0);
        next_cycle();
        ram_ack = 1'b1; ram_rdata = 32'hFFFF_0000;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        next_cycle();
        ram_ack = 1'b0;
        chk("rst_ram_addr", {2'd0, ram_addr}, 32'd0);
        chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
        chk("rst_ram_wdata", ram_wdata, 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);

        // randomized operation mix
        for (int i = 0; i < 200; i++) begin
            int          kind, k;
            logic [31:0] a;
            kind = $urandom_range(0, 19);
            a    = {$urandom} & 32'hFFFF_FFFC;
            if (kind < 3) a[1:0] = 2'($urandom_range(1, 3));
            k = ($urandom_range(0, 9) == 0) ? TMO + 1 : $urandom_range(1, 4);
            if ($urandom_range(0, 29) == 0) k = TMO;
            if (kind == 19)      op(1'b0, 1'b0, a, $urandom, k, $urandom);
            else if (kind < 10)  op(1'b1, 1'b0, a, $urandom, k, $urandom);
            else if (kind < 17)  op(1'b0, 1'b1, a, $urandom, k, $urandom);
            else                 op(1'b1, 1'b1, a, $urandom, k, $urandom);
        end
        op(1'b0, 1'b0, 32'h0, 32'h0, 1, 32'h0);
        op(1'b0, 1'b0, 32'h0, 32'h0, 1, 32'h0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
